// File: rtl/runway_scheduler.sv
// runway_scheduler: grants two runways to the takeoff/landing hold queues,
// issues one CLEAR message per grant, and frees runways on release or timeout.
module runway_scheduler #(
   parameter int unsigned ID_W        = 4,
   parameter int unsigned OCC_TIMEOUT = 1024
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            to_valid,
   input  logic [ID_W-1:0] to_plane_id,
   output logic            to_pop,
   input  logic            ld_valid,
   input  logic [ID_W-1:0] ld_plane_id,
   output logic            ld_pop,
   output logic            clr_valid,
   input  logic            clr_ready,
   output logic [ID_W-1:0] clr_plane_id,
   output logic            clr_runway,
   output logic            clr_landing,
   input  logic            rel_valid,
   input  logic [ID_W-1:0] rel_plane_id,
   output logic            rel_ack,
   output logic            rel_nack,
   input  logic            emerg_set,
   input  logic            emerg_clr,
   output logic            emerg_active,
   output logic [1:0]      runway_active,
   output logic [1:0]      timeout_evt
);

   localparam int unsigned CNT_W = (OCC_TIMEOUT > 2) ? $clog2(OCC_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OCC_TIMEOUT - 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state;
   logic            rr_ld;
   logic [ID_W-1:0] owner   [2];
   logic [CNT_W-1:0] occ_cnt [2];

   logic            grant_c;
   logic            pick_ld_c;
   logic            pick_rw_c;
   logic [1:0]      rel_hit_c;
   logic [1:0]      tmo_hit_c;

   // Grant decision, queue/runway pick, release match and timeout detection on pre-edge state
   always_comb begin
      grant_c   = reset_n && (state == IDLE) && !emerg_active &&
                  (to_valid || ld_valid) && (runway_active != 2'b11);
      pick_ld_c = ld_valid && (!to_valid || rr_ld);
      pick_rw_c = runway_active[0];
      rel_hit_c = 2'b00;
      if (rel_valid) begin
         if (runway_active[0] && (owner[0] == rel_plane_id))
            rel_hit_c = 2'b01;
         else if (runway_active[1] && (owner[1] == rel_plane_id))
            rel_hit_c = 2'b10;
      end
      for (int r = 0; r < 2; r++)
         tmo_hit_c[r] = runway_active[r] && (occ_cnt[r] == CNT_LAST) && !rel_hit_c[r];
   end

   // Pops are issued in the grant-decision cycle so the queue advances at the same edge
   assign to_pop = grant_c && !pick_ld_c;
   assign ld_pop = grant_c && pick_ld_c;

   // Scheduler FSM, runway ownership, timers, release/emergency handling
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         rr_ld         <= 1'b1;
         clr_valid     <= 1'b0;
         clr_plane_id  <= '0;
         clr_runway    <= 1'b0;
         clr_landing   <= 1'b0;
         rel_ack       <= 1'b0;
         rel_nack      <= 1'b0;
         emerg_active  <= 1'b0;
         runway_active <= 2'b00;
         timeout_evt   <= 2'b00;
         for (int r = 0; r < 2; r++) begin
            owner[r]   <= '0;
            occ_cnt[r] <= '0;
         end
      end else begin
         rel_ack     <= |rel_hit_c;
         rel_nack    <= rel_valid && !(|rel_hit_c);
         timeout_evt <= tmo_hit_c;

         if (emerg_set)
            emerg_active <= 1'b1;
         else if (emerg_clr)
            emerg_active <= 1'b0;

         for (int r = 0; r < 2; r++) begin
            if (rel_hit_c[r] || tmo_hit_c[r]) begin
               runway_active[r] <= 1'b0;
               occ_cnt[r]       <= '0;
            end else if (runway_active[r]) begin
               occ_cnt[r] <= occ_cnt[r] + CNT_W'(1);
            end
         end

         case (state)
            IDLE: begin
               if (grant_c) begin
                  runway_active[pick_rw_c] <= 1'b1;
                  owner[pick_rw_c]         <= pick_ld_c ? ld_plane_id : to_plane_id;
                  occ_cnt[pick_rw_c]       <= '0;
                  clr_valid                <= 1'b1;
                  clr_plane_id             <= pick_ld_c ? ld_plane_id : to_plane_id;
                  clr_runway               <= pick_rw_c;
                  clr_landing              <= pick_ld_c;
                  rr_ld                    <= !pick_ld_c;
                  state                    <= ISSUE;
               end
            end
            ISSUE: begin
               if (clr_ready) begin
                  clr_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_runway_scheduler.sv
// tb_runway_scheduler: directed checks of grants, CLEAR handshake, release, timeout, emergency, reset.
module tb_runway_scheduler;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       to_valid, ld_valid, clr_ready, rel_valid, emerg_set, emerg_clr;
   logic [3:0] to_plane_id, ld_plane_id, rel_plane_id;
   logic       to_pop, ld_pop, clr_valid, clr_runway, clr_landing;
   logic       rel_ack, rel_nack, emerg_active;
   logic [3:0] clr_plane_id;
   logic [1:0] runway_active, timeout_evt;

   int total = 0;
   int bad   = 0;

   runway_scheduler #(.ID_W(4), .OCC_TIMEOUT(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .to_valid(to_valid), .to_plane_id(to_plane_id), .to_pop(to_pop),
      .ld_valid(ld_valid), .ld_plane_id(ld_plane_id), .ld_pop(ld_pop),
      .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_plane_id(clr_plane_id),
      .clr_runway(clr_runway), .clr_landing(clr_landing),
      .rel_valid(rel_valid), .rel_plane_id(rel_plane_id),
      .rel_ack(rel_ack), .rel_nack(rel_nack),
      .emerg_set(emerg_set), .emerg_clr(emerg_clr), .emerg_active(emerg_active),
      .runway_active(runway_active), .timeout_evt(timeout_evt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      to_valid = 0; ld_valid = 0; clr_ready = 0; rel_valid = 0;
      emerg_set = 0; emerg_clr = 0;
      to_plane_id = 0; ld_plane_id = 0; rel_plane_id = 0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      do_reset();
      chk("rst_clr_valid", 32'(clr_valid), 0);
      chk("rst_runway_active", 32'(runway_active), 0);
      chk("rst_emerg", 32'(emerg_active), 0);
      chk("rst_flags", 32'({rel_ack, rel_nack, timeout_evt, clr_plane_id}), 0);

      // single landing request
      ld_valid = 1; ld_plane_id = 4'd3; #1;
      chk("s1_ld_pop", 32'(ld_pop), 1);
      chk("s1_to_pop", 32'(to_pop), 0);
      tick(); ld_valid = 0; #1;
      chk("s1_clr_valid", 32'(clr_valid), 1);
      chk("s1_clr_id", 32'(clr_plane_id), 3);
      chk("s1_clr_rw", 32'(clr_runway), 0);
      chk("s1_clr_ld", 32'(clr_landing), 1);
      chk("s1_active", 32'(runway_active), 2'b01);
      chk("s1_ld_pop_off", 32'(ld_pop), 0);
      clr_ready = 1;
      tick(); clr_ready = 0; #1;
      chk("s1_accepted", 32'(clr_valid), 0);

      // both queues: landing first, then takeoff
      do_reset();
      to_valid = 1; to_plane_id = 4'd5; ld_valid = 1; ld_plane_id = 4'd6; #1;
      chk("s2_ld_first", 32'({to_pop, ld_pop}), 2'b01);
      tick(); ld_valid = 0; clr_ready = 1; #1;
      chk("s2_clr1", 32'({clr_valid, clr_plane_id, clr_runway, clr_landing}), {1'b1, 4'd6, 1'b0, 1'b1});
      chk("s2_no_pop_issue", 32'(to_pop), 0);
      tick();
      chk("s2_idle_again", 32'(clr_valid), 0);
      chk("s2_to_pop", 32'(to_pop), 1);
      tick(); to_valid = 0; #1;
      chk("s2_clr2", 32'({clr_valid, clr_plane_id, clr_runway, clr_landing}), {1'b1, 4'd5, 1'b1, 1'b0});
      chk("s2_full", 32'(runway_active), 2'b11);
      tick(); clr_ready = 0;

      // runways full: release and pending grant in the same cycle
      ld_valid = 1; ld_plane_id = 4'd7; rel_valid = 1; rel_plane_id = 4'd5; #1;
      chk("s3_no_grant_full", 32'(ld_pop), 0);
      tick(); rel_valid = 0; #1;
      chk("s3_rel_ack", 32'({rel_ack, rel_nack}), 2'b10);
      chk("s3_rw1_freed", 32'(runway_active), 2'b01);
      chk("s3_ld_pop", 32'(ld_pop), 1);
      tick(); ld_valid = 0; #1;
      chk("s3_clr", 32'({clr_valid, clr_plane_id, clr_runway, clr_landing}), {1'b1, 4'd7, 1'b1, 1'b1});
      chk("s3_rel_ack_pulse", 32'(rel_ack), 0);
      chk("s3_full", 32'(runway_active), 2'b11);

      // occupancy timeout
      do_reset();
      ld_valid = 1; ld_plane_id = 4'd3; #1;
      chk("s4_pop", 32'(ld_pop), 1);
      tick(); ld_valid = 0; clr_ready = 1;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("s4_held", 32'({runway_active, timeout_evt}), {2'b01, 2'b00});
      end
      tick();
      chk("s4_timeout", 32'({runway_active, timeout_evt}), {2'b00, 2'b01});
      tick();
      chk("s4_evt_pulse", 32'(timeout_evt), 0);

      // emergency gating and unmatched release
      emerg_set = 1;
      tick(); emerg_set = 0; #1;
      chk("s5_emerg_on", 32'(emerg_active), 1);
      to_valid = 1; to_plane_id = 4'd2; #1;
      chk("s5_no_pop", 32'(to_pop), 0);
      tick();
      chk("s5_no_pop2", 32'({to_pop, clr_valid}), 0);
      emerg_clr = 1; #1;
      chk("s5_no_pop3", 32'(to_pop), 0);
      tick(); emerg_clr = 0; #1;
      chk("s5_emerg_off", 32'(emerg_active), 0);
      chk("s5_resume", 32'(to_pop), 1);
      tick(); to_valid = 0; #1;
      chk("s5_clr", 32'({clr_valid, clr_plane_id, clr_runway, clr_landing}), {1'b1, 4'd2, 1'b0, 1'b0});
      emerg_set = 1; emerg_clr = 1;
      tick(); emerg_set = 0; #1;
      chk("s5_set_wins", 32'(emerg_active), 1);
      tick(); emerg_clr = 0; #1;
      chk("s5_clr_only", 32'(emerg_active), 0);
      rel_valid = 1; rel_plane_id = 4'd9;
      tick(); rel_valid = 0; #1;
      chk("s5_nack", 32'({rel_ack, rel_nack}), 2'b01);
      chk("s5_rw0_kept", 32'(runway_active[0]), 1);
      tick();
      chk("s5_nack_pulse", 32'(rel_nack), 0);

      // backpressure on CLEAR, then reset mid-ISSUE
      do_reset();
      ld_valid = 1; ld_plane_id = 4'd4; to_valid = 1; to_plane_id = 4'd1; #1;
      chk("s6_pop", 32'({to_pop, ld_pop}), 2'b01);
      tick(); ld_valid = 0; #1;
      for (int k = 0; k < 5; k++) begin
         chk("s6_stable", 32'({clr_valid, clr_plane_id, clr_runway, clr_landing}), {1'b1, 4'd4, 1'b0, 1'b1});
         chk("s6_no_pop", 32'({to_pop, ld_pop}), 0);
         tick();
      end
      reset_n = 0; #1;
      chk("s6_rst_no_pop", 32'(to_pop), 0);
      tick();
      chk("s6_rst_outs", 32'({clr_valid, clr_plane_id, clr_runway, clr_landing, rel_ack, rel_nack,
                              emerg_active, runway_active, timeout_evt}), 0);
      to_valid = 0; reset_n = 1;
      tick();
      chk("s6_no_replay", 32'({clr_valid, runway_active}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
